// File: rtl/processor_pkg.sv
// Shared pipeline definitions: opcode field geometry, the NOP encoding and the fetch FSM states.
package processor_pkg;

    localparam int unsigned OPCODE_W = 5;
    localparam int unsigned WORD_W   = 16;

    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_IMM  = 2'd2
    } fetch_state_e;

    // An instruction carries a trailing immediate word when the opcode's two top bits are set.
    function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
        return opcode[OPCODE_W-1 -: 2] == 2'b11;
    endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: loads a fetched instruction, holds it, or flushes to a NOP bubble.
module if_id_buffer
    import processor_pkg::*;
#(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instruction_d,
    input  logic [INSTR_W-1:0] immediate_d,
    input  logic [PC_W-1:0]    pc_next_d,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] immediate,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_next_buf
);

    // Flush beats load; with neither asserted the contents are held.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instruction <= INSTR_W'(NOP_INSTR);
            immediate   <= '0;
            instr_valid <= 1'b0;
            pc_next_buf <= '0;
        end else if (load) begin
            instruction <= instruction_d;
            immediate   <= immediate_d;
            instr_valid <= 1'b1;
            pc_next_buf <= pc_next_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: boots the PC from imem, splits two-word instructions and
// feeds the IF/ID buffer, honouring stall and jump redirects from later stages.
module fetch_stage
    import processor_pkg::*;
#(
    parameter int unsigned      PC_W      = 16,
    parameter int unsigned      INSTR_W   = 16,
    parameter logic [PC_W-1:0]  RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               jump_occured,
    input  logic [PC_W-1:0]    jump_target,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] immediate,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_next_buf
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] held_q, held_d;

    logic               buf_load, buf_flush;
    logic [INSTR_W-1:0] buf_instr, buf_imm;
    logic [PC_W-1:0]    pc_inc;
    logic               fetch_two_word;

    assign pc_inc         = pc_q + PC_W'(1);
    assign fetch_two_word = is_two_word(imem_data[INSTR_W-1 -: OPCODE_W]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            held_q  <= held_d;
        end
    end

    // Next-state logic; jump takes priority over stall so a flush is never lost.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        held_d    = held_q;
        imem_addr = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_instr = INSTR_W'(NOP_INSTR);
        buf_imm   = '0;

        unique case (state_q)
            S_BOOT: begin
                imem_addr = RESET_VEC;
                pc_d      = imem_data[PC_W-1:0];
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (jump_occured) begin
                    pc_d      = jump_target;
                    buf_flush = 1'b1;
                end else if (!stall) begin
                    pc_d = pc_inc;
                    if (fetch_two_word) begin
                        held_d    = imem_data;
                        buf_flush = 1'b1;
                        state_d   = S_IMM;
                    end else begin
                        buf_load  = 1'b1;
                        buf_instr = imem_data;
                    end
                end
            end
            S_IMM: begin
                if (jump_occured) begin
                    pc_d      = jump_target;
                    held_d    = '0;
                    buf_flush = 1'b1;
                    state_d   = S_RUN;
                end else if (!stall) begin
                    pc_d      = pc_inc;
                    buf_load  = 1'b1;
                    buf_instr = held_q;
                    buf_imm   = imem_data;
                    state_d   = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    if_id_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_buffer (
        .clk           (clk),
        .reset         (reset),
        .load          (buf_load),
        .flush         (buf_flush),
        .instruction_d (buf_instr),
        .immediate_d   (buf_imm),
        .pc_next_d     (pc_inc),
        .instruction   (instruction),
        .immediate     (immediate),
        .instr_valid   (instr_valid),
        .pc_next_buf   (pc_next_buf)
    );

endmodule
